pwr_seq_gen: RTL and testbench

//  Generic ordered power sequencer for macro power domains (MRAM, SRAM banks, analog rails).

---
 rtl/pwr_seq_pkg.sv | 13 +
 rtl/pwr_seq_dwell_cnt.sv | 20 ++
 rtl/pwr_seq_gen.sv | 150 +++++++++++++++
 tb/tb_pwr_seq_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pwr_seq_pkg.sv
// pwr_seq_pkg: shared state encoding and default timing constants for the power sequencer
package pwr_seq_pkg;
    typedef logic [2:0] pwr_seq_state_e;
    localparam pwr_seq_state_e S_OFF = 3'd0;
    localparam pwr_seq_state_e S_UP  = 3'd1;
    localparam pwr_seq_state_e S_ACK = 3'd2;
    localparam pwr_seq_state_e S_ON  = 3'd3;
    localparam pwr_seq_state_e S_DN  = 3'd4;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_TMO_W = 12;
    localparam int DEF_DLY   = 2;
    localparam int DEF_TMO   = 10;
endpackage

// File: rtl/pwr_seq_dwell_cnt.sv
// pwr_seq_dwell_cnt: saturating up-counter with clear and ==limit compare
module pwr_seq_dwell_cnt
    import pwr_seq_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] lim_i,
    output logic         hit_o
);
    logic [W-1:0] cnt_q;
    assign hit_o = cnt_q == lim_i;
    always_ff @(posedge clk) begin
        if (rst || clr_i) cnt_q <= '0;
        else if (inc_i && !hit_o) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/pwr_seq_gen.sv
// pwr_seq_gen: ordered power sequencer raising control lines in ascending order and
// dropping them in descending order, with per-step dwell, optional ack wait and reversal.
module pwr_seq_gen
    import pwr_seq_pkg::*;
#(
    parameter int                   N_STEPS      = 4,
    parameter int                   CNT_W        = DEF_CNT_W,
    parameter int                   TMO_W        = DEF_TMO_W,
    parameter logic [N_STEPS-1:0]   ACT_LOW_MASK = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         power_req,
    input  logic [N_STEPS*CNT_W-1:0]     dly_cfg,
    input  logic [N_STEPS-1:0]           ack_en,
    input  logic [N_STEPS-1:0]           ack_i,
    input  logic [TMO_W-1:0]             tmo_cfg,
    output logic [N_STEPS-1:0]           ctrl_o,
    output logic [$clog2(N_STEPS+1)-1:0] step_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);
    localparam int IW = $clog2(N_STEPS);
    localparam int SW = $clog2(N_STEPS+1);
    localparam logic [IW-1:0] LAST = IW'(N_STEPS-1);

    pwr_seq_state_e     state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [N_STEPS-1:0] lvl_q, lvl_d, ctrl_q;
    logic [SW-1:0]      step_q, step_d;
    logic               err_q, err_d, adv, dwell_hit, tmo_hit;

    pwr_seq_dwell_cnt #(.W(CNT_W)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clr_i ((state_d != state_q) || (idx_d != idx_q)),
        .inc_i (state_q == S_UP || state_q == S_DN),
        .lim_i (dly_cfg[CNT_W*int'(idx_q) +: CNT_W]),
        .hit_o (dwell_hit)
    );

    pwr_seq_dwell_cnt #(.W(TMO_W)) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != S_ACK),
        .inc_i (state_q == S_ACK),
        .lim_i (tmo_cfg),
        .hit_o (tmo_hit)
    );

    // Reversal is tested first in every busy state so it wins over dwell completion and ack.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lvl_d   = lvl_q;
        err_d   = err_q;
        adv     = 1'b0;
        case (state_q)
            S_OFF: begin
                if (!power_req) err_d = 1'b0;
                else if (!err_q) begin
                    state_d  = S_UP;
                    idx_d    = '0;
                    lvl_d[0] = 1'b1;
                end
            end
            S_UP: begin
                if (!power_req) begin
                    state_d      = S_DN;
                    lvl_d[idx_q] = 1'b0;
                end else if (dwell_hit) begin
                    if (ack_en[idx_q]) state_d = S_ACK;
                    else adv = 1'b1;
                end
            end
            S_ACK: begin
                if (!power_req) begin
                    state_d      = S_DN;
                    lvl_d[idx_q] = 1'b0;
                end else if (ack_i[idx_q]) adv = 1'b1;
                else if (tmo_hit) begin
                    err_d        = 1'b1;
                    state_d      = S_DN;
                    lvl_d[idx_q] = 1'b0;
                end
            end
            S_ON: begin
                if (!power_req) begin
                    state_d     = S_DN;
                    idx_d       = LAST;
                    lvl_d[LAST] = 1'b0;
                end
            end
            S_DN: begin
                if (power_req && !err_q) begin
                    state_d      = S_UP;
                    lvl_d[idx_q] = 1'b1;
                end else if (dwell_hit) begin
                    if (idx_q == '0) state_d = S_OFF;
                    else begin
                        idx_d             = idx_q - 1'b1;
                        lvl_d[idx_q-1'b1] = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_OFF;
                lvl_d   = '0;
            end
        endcase
        if (adv) begin
            if (idx_q == LAST) state_d = S_ON;
            else begin
                state_d           = S_UP;
                idx_d             = idx_q + 1'b1;
                lvl_d[idx_q+1'b1] = 1'b1;
            end
        end
    end

    always_comb begin
        step_d = '0;
        for (int k = 0; k < N_STEPS; k++) step_d = step_d + SW'(lvl_d[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            idx_q   <= '0;
            lvl_q   <= '0;
            err_q   <= 1'b0;
            ctrl_q  <= ACT_LOW_MASK;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lvl_q   <= lvl_d;
            err_q   <= err_d;
            ctrl_q  <= lvl_d ^ ACT_LOW_MASK;
            step_q  <= step_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign step_o = step_q;
    assign err_o  = err_q;
    assign busy_o = state_q == S_UP || state_q == S_DN;
    assign done_o = (power_req && state_q == S_ON) || (!power_req && state_q == S_OFF && !err_q);
endmodule

// File: tb/tb_pwr_seq_gen.sv
// tb_pwr_seq_gen: vector table, directed corner sequences and random stimulus against a level-count model
module tb_pwr_seq_gen;
    localparam int N = 4, CW = 8, TW = 12;
    localparam logic [3:0] MASK = 4'b1000;
    localparam int IDLE = 0, RISE = 1, AWAIT = 2, HOLD = 3, FALL = 4;

    logic clk = 1'b0, rst, power_req;
    logic [N*CW-1:0] dly_cfg;
    logic [N-1:0] ack_en, ack_i, ctrl_o;
    logic [TW-1:0] tmo_cfg;
    logic [2:0] step_o;
    logic busy_o, done_o, err_o;

    always #5 clk = ~clk;

    pwr_seq_gen #(.N_STEPS(N), .CNT_W(CW), .TMO_W(TW), .ACT_LOW_MASK(MASK)) dut (
        .clk(clk), .rst(rst), .power_req(power_req), .dly_cfg(dly_cfg), .ack_en(ack_en),
        .ack_i(ack_i), .tmo_cfg(tmo_cfg), .ctrl_o(ctrl_o), .step_o(step_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    int total = 0, bad = 0;
    int dk[N];
    int m_lv = 0, m_mode = IDLE, m_rem = 0, m_tleft = 0;
    bit m_err = 0;

    typedef struct {
        bit rst; bit pr; int n; logic [3:0] ctrl; int step; bit busy; bit done;
    } vec_t;
    vec_t tbl[11];

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void cfg_apply();
        for (int k = 0; k < N; k++) dly_cfg[k*CW +: CW] = CW'(dk[k]);
    endfunction

    // Model tracks how many lines are up plus a countdown of remaining dwell/ack cycles.
    function automatic void m_go_fall(int lv);
        m_mode = FALL; m_lv = lv; m_rem = dk[lv];
    endfunction

    function automatic void m_adv();
        if (m_lv == N) m_mode = HOLD;
        else begin m_mode = RISE; m_lv++; m_rem = dk[m_lv-1]; end
    endfunction

    function automatic void model_step();
        int k;
        if (rst) begin
            m_lv = 0; m_mode = IDLE; m_err = 0; m_rem = 0;
            return;
        end
        case (m_mode)
            IDLE: if (!power_req) m_err = 0;
                  else if (!m_err) begin m_mode = RISE; m_lv = 1; m_rem = dk[0]; end
            RISE: begin
                k = m_lv - 1;
                if (!power_req) m_go_fall(k);
                else if (m_rem == 0) begin
                    if (ack_en[k]) begin m_mode = AWAIT; m_tleft = int'(tmo_cfg); end
                    else m_adv();
                end else m_rem--;
            end
            AWAIT: begin
                k = m_lv - 1;
                if (!power_req) m_go_fall(k);
                else if (ack_i[k]) m_adv();
                else if (m_tleft == 0) begin m_err = 1; m_go_fall(k); end
                else m_tleft--;
            end
            HOLD: if (!power_req) m_go_fall(N-1);
            default: begin
                k = m_lv;
                if (power_req && !m_err) begin m_mode = RISE; m_lv = k + 1; m_rem = dk[k]; end
                else if (m_rem == 0) begin
                    if (k == 0) m_mode = IDLE;
                    else begin m_lv = k - 1; m_rem = dk[k-1]; end
                end else m_rem--;
            end
        endcase
    endfunction

    task automatic check();
        cmp("m_ctrl", 32'(ctrl_o), 32'(((1 << m_lv) - 1) ^ int'(MASK)));
        cmp("m_step", 32'(step_o), 32'(m_lv));
        cmp("m_busy", 32'(busy_o), 32'(m_mode == RISE || m_mode == FALL));
        cmp("m_err", 32'(err_o), 32'(m_err));
        cmp("m_done", 32'(done_o), 32'((power_req && m_mode == HOLD) || (!power_req && m_mode == IDLE && !m_err)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check();
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    initial begin
        tbl[0]  = '{1, 0, 2, 4'b1000, 0, 0, 1};
        tbl[1]  = '{0, 1, 1, 4'b1001, 1, 1, 0};
        tbl[2]  = '{0, 1, 3, 4'b1011, 2, 1, 0};
        tbl[3]  = '{0, 1, 3, 4'b1111, 3, 1, 0};
        tbl[4]  = '{0, 1, 3, 4'b0111, 4, 1, 0};
        tbl[5]  = '{0, 1, 3, 4'b0111, 4, 0, 1};
        tbl[6]  = '{0, 0, 1, 4'b1111, 3, 1, 0};
        tbl[7]  = '{0, 0, 3, 4'b1011, 2, 1, 0};
        tbl[8]  = '{0, 0, 3, 4'b1001, 1, 1, 0};
        tbl[9]  = '{0, 0, 3, 4'b1000, 0, 1, 0};
        tbl[10] = '{0, 0, 3, 4'b1000, 0, 0, 1};
        rst = 1; power_req = 0; ack_en = 0; ack_i = 0; tmo_cfg = 10;
        for (int k = 0; k < N; k++) dk[k] = 2;
        cfg_apply();
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; power_req = tbl[i].pr;
            run(tbl[i].n);
            cmp($sformatf("vec%0d_ctrl", i), 32'(ctrl_o), 32'(tbl[i].ctrl));
            cmp($sformatf("vec%0d_step", i), 32'(step_o), 32'(tbl[i].step));
            cmp($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
            cmp($sformatf("vec%0d_done", i), 32'(done_o), 32'(tbl[i].done));
            cmp($sformatf("vec%0d_err", i), 32'(err_o), 32'(0));
        end
        // late ack on step 2
        ack_en = 4'b0100; tmo_cfg = 10; power_req = 1;
        run(15);
        cmp("t3_wait_step", 32'(step_o), 32'(3));
        ack_i = 4'b0100;
        run(1);
        cmp("t3_late_step", 32'(step_o), 32'(4));
        cmp("t3_err", 32'(err_o), 32'(0));
        run(3);
        cmp("t3_on_done", 32'(done_o), 32'(1));
        ack_i = 0; power_req = 0;
        run(14);
        // ack timeout on step 1
        ack_en = 4'b0010; tmo_cfg = 4; power_req = 1;
        run(11);
        cmp("t4_pre_err", 32'(err_o), 32'(0));
        cmp("t4_pre_step", 32'(step_o), 32'(2));
        run(1);
        cmp("t4_err_set", 32'(err_o), 32'(1));
        cmp("t4_err_step", 32'(step_o), 32'(1));
        run(6);
        cmp("t4_off_step", 32'(step_o), 32'(0));
        cmp("t4_off_busy", 32'(busy_o), 32'(0));
        cmp("t4_off_done", 32'(done_o), 32'(0));
        run(5);
        cmp("t4_hold_off", 32'(step_o), 32'(0));
        power_req = 0;
        run(1);
        cmp("t4_err_clr", 32'(err_o), 32'(0));
        ack_en = 0; power_req = 1;
        run(1);
        cmp("t4_restart", 32'(step_o), 32'(1));
        power_req = 0;
        run(4);
        // reversal mid-sequence both ways
        power_req = 1;
        run(8);
        power_req = 0;
        run(1);
        cmp("t5_rev_ctrl", 32'(ctrl_o), 32'(4'b1011));
        cmp("t5_rev_busy", 32'(busy_o), 32'(1));
        run(3);
        cmp("t5_dn_step", 32'(step_o), 32'(1));
        run(1);
        power_req = 1;
        run(1);
        cmp("t5_reup_step", 32'(step_o), 32'(2));
        run(3);
        cmp("t5_next_step", 32'(step_o), 32'(3));
        // reset mid-UP
        rst = 1;
        run(1);
        cmp("t6_ctrl", 32'(ctrl_o), 32'(4'b1000));
        cmp("t6_step", 32'(step_o), 32'(0));
        cmp("t6_busy", 32'(busy_o), 32'(0));
        rst = 0; power_req = 0;
        run(2);
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) begin
                rst = 1;
                for (int k = 0; k < N; k++) dk[k] = $urandom_range(0, 3);
                cfg_apply();
                tmo_cfg = TW'($urandom_range(0, 6));
                ack_en = N'($urandom);
            end else rst = 0;
            if ($urandom_range(0, 19) == 0) power_req = ~power_req;
            ack_i = N'($urandom);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
